// File: rtl/tb_watchdog_mc.sv
// Multi-channel watchdog with sticky per-channel expiry, first-expired capture and a test-status level.
// Optional TB_WATCHDOG_LOG_EN compiles in log messages and a $finish on FATAL (simulation only).
module tb_watchdog_mc #(
  parameter  int NUM_CH        = 4,
  parameter  int CNT_W         = 16,
  parameter  int DEFAULT_LIMIT = 1000,
  parameter  int FATAL_THRESH  = 2,
  localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] arm_i,
  input  logic [NUM_CH-1:0] kick_i,
  input  logic              cfg_we_i,
  input  logic [CH_W-1:0]   cfg_ch_i,
  input  logic [CNT_W-1:0]  cfg_limit_i,
  input  logic              clear_i,
  input  logic              done_i,
  output logic [NUM_CH-1:0] expired_o,
  output logic              any_expired_o,
  output logic              first_valid_o,
  output logic [CH_W-1:0]   first_ch_o,
  output logic [1:0]        level_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COUNTING = 2'd1,
    EXPIRED  = 2'd2
  } ch_state_t;

  typedef enum logic [1:0] {
    INFO    = 2'd0,
    ERROR   = 2'd1,
    FATAL   = 2'd2,
    SUCCESS = 2'd3
  } level_t;

  ch_state_t         state     [NUM_CH];
  ch_state_t         state_nxt [NUM_CH];
  logic [CNT_W-1:0]  count     [NUM_CH];
  logic [CNT_W-1:0]  count_nxt [NUM_CH];
  logic [CNT_W-1:0]  limit     [NUM_CH];
  logic [NUM_CH-1:0] exp_q;
  logic [NUM_CH-1:0] exp_nxt;
  logic [NUM_CH-1:0] newly;
  level_t            level;
  level_t            level_nxt;
  logic              first_valid;
  logic              first_valid_nxt;
  logic [CH_W-1:0]   first_ch;
  logic [CH_W-1:0]   first_ch_nxt;
  int                n_exp;

  // Per-channel next state; the +1 compare is one bit wider so an all-ones count cannot wrap.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_nxt[i] = state[i];
      count_nxt[i] = count[i];
      if (clear_i) begin
        state_nxt[i] = IDLE;
        count_nxt[i] = '0;
      end else begin
        case (state[i])
          IDLE: begin
            if (arm_i[i]) begin
              state_nxt[i] = COUNTING;
              count_nxt[i] = '0;
            end
          end
          COUNTING: begin
            if (!arm_i[i]) begin
              state_nxt[i] = IDLE;
              count_nxt[i] = '0;
            end else if (kick_i[i]) begin
              count_nxt[i] = '0;
            end else if ((limit[i] != '0) &&
                         (({1'b0, count[i]} + (CNT_W+1)'(1)) >= {1'b0, limit[i]})) begin
              state_nxt[i] = EXPIRED;
            end else if ((limit[i] != '0) && (count[i] != '1)) begin
              count_nxt[i] = count[i] + CNT_W'(1);
            end
          end
          EXPIRED: begin
            state_nxt[i] = EXPIRED;
          end
          default: begin
            state_nxt[i] = IDLE;
            count_nxt[i] = '0;
          end
        endcase
      end
      exp_nxt[i] = (state_nxt[i] == EXPIRED);
      newly[i]   = exp_nxt[i] && (state[i] != EXPIRED);
    end
  end

  // Status is judged on the next-state expiry vector so it moves on the same edge as expired_o.
  always_comb begin
    n_exp = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      n_exp = n_exp + int'(exp_nxt[i]);
    end

    level_nxt = level;
    if (clear_i) begin
      level_nxt = INFO;
    end else if (n_exp >= FATAL_THRESH) begin
      level_nxt = FATAL;
    end else if (|exp_nxt) begin
      level_nxt = (level == FATAL) ? FATAL : ERROR;
    end else if (done_i && (level == INFO)) begin
      level_nxt = SUCCESS;
    end

    first_valid_nxt = first_valid;
    first_ch_nxt    = first_ch;
    if (clear_i) begin
      first_valid_nxt = 1'b0;
      first_ch_nxt    = '0;
    end else if (!first_valid && (|newly)) begin
      first_valid_nxt = 1'b1;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (newly[i]) begin
          first_ch_nxt = CH_W'(i);
        end
      end
    end
  end

  // Limit writes to an out-of-range channel match no index and are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state[i] <= IDLE;
        count[i] <= '0;
        limit[i] <= CNT_W'(DEFAULT_LIMIT);
      end
      exp_q       <= '0;
      level       <= INFO;
      first_valid <= 1'b0;
      first_ch    <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state[i] <= state_nxt[i];
        count[i] <= count_nxt[i];
        if (cfg_we_i && (cfg_ch_i == CH_W'(i))) begin
          limit[i] <= cfg_limit_i;
        end
      end
      exp_q       <= exp_nxt;
      level       <= level_nxt;
      first_valid <= first_valid_nxt;
      first_ch    <= first_ch_nxt;
    end
  end

  assign expired_o     = exp_q;
  assign any_expired_o = |exp_q;
  assign first_valid_o = first_valid;
  assign first_ch_o    = first_ch;
  assign level_o       = level;

`ifdef TB_WATCHDOG_LOG_EN
  always @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (newly[i]) begin
          $display("[%0t] [WATCHDOG] ERROR : channel %0d expired (%0d cycles)", $time, i, limit[i]);
        end
      end
      if ((level_nxt == SUCCESS) && (level != SUCCESS)) begin
        $display("[%0t] [WATCHDOG] SUCCESS : test done", $time);
      end
      if ((level_nxt == FATAL) && (level != FATAL)) begin
        $display("[%0t] [WATCHDOG] FATAL : %0d channels expired", $time, n_exp);
        $finish;
      end
    end
  end
`else
`endif

endmodule

// File: tb/tb_tb_watchdog_mc.sv
// Directed bench for tb_watchdog_mc with default parameters (4 channels, FATAL_THRESH=2).
module tb_tb_watchdog_mc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  arm_i;
  logic [3:0]  kick_i;
  logic        cfg_we_i;
  logic [1:0]  cfg_ch_i;
  logic [15:0] cfg_limit_i;
  logic        clear_i;
  logic        done_i;
  logic [3:0]  expired_o;
  logic        any_expired_o;
  logic        first_valid_o;
  logic [1:0]  first_ch_o;
  logic [1:0]  level_o;

  int checks = 0;
  int errors = 0;

  tb_watchdog_mc dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .arm_i         (arm_i),
    .kick_i        (kick_i),
    .cfg_we_i      (cfg_we_i),
    .cfg_ch_i      (cfg_ch_i),
    .cfg_limit_i   (cfg_limit_i),
    .clear_i       (clear_i),
    .done_i        (done_i),
    .expired_o     (expired_o),
    .any_expired_o (any_expired_o),
    .first_valid_o (first_valid_o),
    .first_ch_o    (first_ch_o),
    .level_o       (level_o)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    arm_i       = '0;
    kick_i      = '0;
    cfg_we_i    = 1'b0;
    cfg_ch_i    = '0;
    cfg_limit_i = '0;
    clear_i     = 1'b0;
    done_i      = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [15:0] lim);
    cfg_we_i    = 1'b1;
    cfg_ch_i    = ch;
    cfg_limit_i = lim;
    step();
    cfg_we_i    = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (expired_o !== 4'b0000) begin errors++; $display("[TB] FAIL reset_expired got=%b exp=0000", expired_o); end
    checks++;
    if (any_expired_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_any got=%b exp=0", any_expired_o); end
    checks++;
    if (first_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_first_valid got=%b exp=0", first_valid_o); end
    checks++;
    if (first_ch_o !== 2'd0) begin errors++; $display("[TB] FAIL reset_first_ch got=%0d exp=0", first_ch_o); end
    checks++;
    if (level_o !== 2'd0) begin errors++; $display("[TB] FAIL reset_level got=%0d exp=0", level_o); end
  endtask

  task automatic test_single_expiry();
    logic [3:0] exp_v;
    do_reset();
    cfg_write(2'd0, 16'd5);
    arm_i = 4'b0001;
    for (int k = 0; k <= 5; k++) begin
      step();
      exp_v = (k == 5) ? 4'b0001 : 4'b0000;
      checks++;
      if (expired_o !== exp_v) begin errors++; $display("[TB] FAIL single_edge%0d got=%b exp=%b", k, expired_o, exp_v); end
    end
    checks++;
    if (first_valid_o !== 1'b1 || first_ch_o !== 2'd0) begin
      errors++; $display("[TB] FAIL single_first got=%b/%0d exp=1/0", first_valid_o, first_ch_o);
    end
    checks++;
    if (level_o !== 2'd1 || any_expired_o !== 1'b1) begin
      errors++; $display("[TB] FAIL single_level got=%0d/%b exp=1/1", level_o, any_expired_o);
    end
    arm_i  = 4'b0000;
    kick_i = 4'b0001;
    step();
    kick_i = 4'b0000;
    checks++;
    if (expired_o !== 4'b0001) begin errors++; $display("[TB] FAIL single_sticky got=%b exp=0001", expired_o); end
  endtask

  task automatic test_kick();
    logic [3:0] exp_v;
    do_reset();
    cfg_write(2'd1, 16'd5);
    arm_i = 4'b0010;
    for (int k = 0; k <= 12; k++) begin
      kick_i = (k == 3 || k == 7) ? 4'b0010 : 4'b0000;
      step();
      exp_v = (k >= 12) ? 4'b0010 : 4'b0000;
      checks++;
      if (expired_o !== exp_v) begin errors++; $display("[TB] FAIL kick_edge%0d got=%b exp=%b", k, expired_o, exp_v); end
    end
    kick_i = 4'b0000;
    checks++;
    if (first_ch_o !== 2'd1) begin errors++; $display("[TB] FAIL kick_first_ch got=%0d exp=1", first_ch_o); end
  endtask

  task automatic test_fatal();
    do_reset();
    cfg_write(2'd2, 16'd4);
    cfg_write(2'd3, 16'd4);
    arm_i = 4'b1100;
    for (int k = 0; k <= 3; k++) begin
      step();
      checks++;
      if (expired_o !== 4'b0000) begin errors++; $display("[TB] FAIL fatal_pre_edge%0d got=%b exp=0000", k, expired_o); end
    end
    step();
    checks++;
    if (expired_o !== 4'b1100) begin errors++; $display("[TB] FAIL fatal_expired got=%b exp=1100", expired_o); end
    checks++;
    if (first_ch_o !== 2'd2 || level_o !== 2'd2) begin
      errors++; $display("[TB] FAIL fatal_status got=ch%0d/lvl%0d exp=ch2/lvl2", first_ch_o, level_o);
    end

    do_reset();
    cfg_write(2'd2, 16'd4);
    cfg_write(2'd3, 16'd4);
    arm_i = 4'b1100;
    for (int k = 0; k <= 8; k++) begin
      kick_i = (k == 4) ? 4'b1000 : 4'b0000;
      step();
      if (k == 4) begin
        checks++;
        if (expired_o !== 4'b0100 || level_o !== 2'd1 || first_ch_o !== 2'd2) begin
          errors++; $display("[TB] FAIL kick_on_expiry got=%b/lvl%0d/ch%0d exp=0100/lvl1/ch2", expired_o, level_o, first_ch_o);
        end
      end
      if (k == 7) begin
        checks++;
        if (level_o !== 2'd1) begin errors++; $display("[TB] FAIL late_pre_level got=%0d exp=1", level_o); end
      end
    end
    kick_i = 4'b0000;
    checks++;
    if (expired_o !== 4'b1100 || level_o !== 2'd2 || first_ch_o !== 2'd2) begin
      errors++; $display("[TB] FAIL late_fatal got=%b/lvl%0d/ch%0d exp=1100/lvl2/ch2", expired_o, level_o, first_ch_o);
    end
  endtask

  task automatic test_disarm();
    do_reset();
    cfg_write(2'd0, 16'd3);
    arm_i = 4'b0001;
    repeat (3) step();
    arm_i = 4'b0000;
    repeat (3) step();
    checks++;
    if (expired_o !== 4'b0000 || level_o !== 2'd0) begin
      errors++; $display("[TB] FAIL disarm_wins got=%b/lvl%0d exp=0000/lvl0", expired_o, level_o);
    end
  endtask

  task automatic test_limit_write();
    bit seen;
    do_reset();
    cfg_write(2'd0, 16'd20);
    arm_i = 4'b0001;
    repeat (9) step();
    cfg_write(2'd0, 16'd3);
    step();
    checks++;
    if (expired_o !== 4'b0001) begin errors++; $display("[TB] FAIL limit_lower got=%b exp=0001", expired_o); end

    do_reset();
    cfg_write(2'd0, 16'd20);
    arm_i = 4'b0001;
    repeat (9) step();
    cfg_write(2'd0, 16'd0);
    seen = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      step();
      if (expired_o !== 4'b0000) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || level_o !== 2'd0) begin
      errors++; $display("[TB] FAIL limit_zero got=seen%b/lvl%0d exp=seen0/lvl0", seen, level_o);
    end
  endtask

  task automatic test_success_clear();
    do_reset();
    cfg_write(2'd0, 16'd5);
    done_i = 1'b1;
    step();
    done_i = 1'b0;
    checks++;
    if (level_o !== 2'd3) begin errors++; $display("[TB] FAIL success_level got=%0d exp=3", level_o); end
    arm_i = 4'b0001;
    repeat (6) step();
    checks++;
    if (level_o !== 2'd1 || expired_o !== 4'b0001) begin
      errors++; $display("[TB] FAIL success_to_error got=lvl%0d/%b exp=lvl1/0001", level_o, expired_o);
    end
    done_i = 1'b1;
    step();
    done_i = 1'b0;
    checks++;
    if (level_o !== 2'd1) begin errors++; $display("[TB] FAIL done_ignored got=%0d exp=1", level_o); end
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    checks++;
    if (level_o !== 2'd0 || expired_o !== 4'b0000 || first_valid_o !== 1'b0 || any_expired_o !== 1'b0) begin
      errors++; $display("[TB] FAIL clear got=lvl%0d/%b/fv%b/any%b exp=lvl0/0000/fv0/any0", level_o, expired_o, first_valid_o, any_expired_o);
    end
    repeat (5) step();
    checks++;
    if (expired_o !== 4'b0000) begin errors++; $display("[TB] FAIL rearm_early got=%b exp=0000", expired_o); end
    step();
    checks++;
    if (expired_o !== 4'b0001 || first_valid_o !== 1'b1) begin
      errors++; $display("[TB] FAIL rearm_limit_kept got=%b/fv%b exp=0001/fv1", expired_o, first_valid_o);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    cfg_write(2'd0, 16'd2);
    cfg_write(2'd1, 16'd10);
    arm_i = 4'b0011;
    repeat (4) step();
    checks++;
    if (expired_o !== 4'b0001 || level_o !== 2'd1) begin
      errors++; $display("[TB] FAIL async_pre got=%b/lvl%0d exp=0001/lvl1", expired_o, level_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (expired_o !== 4'b0000 || level_o !== 2'd0 || first_valid_o !== 1'b0 || any_expired_o !== 1'b0) begin
      errors++; $display("[TB] FAIL async_reset got=%b/lvl%0d/fv%b/any%b exp=0000/lvl0/fv0/any0", expired_o, level_o, first_valid_o, any_expired_o);
    end
    arm_i = 4'b0000;
    step();
    rst_n = 1'b1;
    step();
    arm_i = 4'b0001;
    repeat (1000) step();
    checks++;
    if (expired_o !== 4'b0000) begin errors++; $display("[TB] FAIL default_limit_early got=%b exp=0000", expired_o); end
    step();
    checks++;
    if (expired_o !== 4'b0001) begin errors++; $display("[TB] FAIL default_limit got=%b exp=0001", expired_o); end
  endtask

  initial begin
    test_reset();
    test_single_expiry();
    test_kick();
    test_fatal();
    test_disarm();
    test_limit_write();
    test_success_clear();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tb_watchdog_mc.md
Name: tb_watchdog_mc

Overview:
- Parametrised multi-channel watchdog and status monitor for benches; the next generation of the single-counter timeout task.
- Each channel has a programmable timeout, an arm control and a kick (progress) input.
- Aggregates per-channel expiries into a sticky 2-bit test-status level: INFO, ERROR, FATAL or SUCCESS.
- Instantiated in a testbench top beside the DUT; the core is synthesizable so it can also sit in FPGA debug builds.

Parameters:
- NUM_CH, 4: number of watchdog channels (1..32).
- CNT_W, 16: counter and limit width.
- DEFAULT_LIMIT, 1000: per-channel limit loaded at reset; must fit in CNT_W.
- FATAL_THRESH, 2: number of simultaneously expired channels that escalates status to FATAL (1..NUM_CH).

Ports:
- clk  in  1  bench clock.
- rst_n  in  1  asynchronous, active-low reset.
- arm_i  in  NUM_CH  per-channel arm; level-sensitive.
- kick_i  in  NUM_CH  per-channel progress pulse; restarts the count.
- cfg_we_i  in  1  limit write strobe.
- cfg_ch_i  in  $clog2(NUM_CH) (min 1)  channel select for the limit write.
- cfg_limit_i  in  CNT_W  new limit; 0 disables expiry for that channel.
- clear_i  in  1  clears all expiries, first-capture and status.
- done_i  in  1  end-of-test pulse.
- expired_o  out  NUM_CH  sticky per-channel expiry flags.
- any_expired_o  out  1  OR of expired_o.
- first_valid_o  out  1  first-expired capture is valid.
- first_ch_o  out  $clog2(NUM_CH) (min 1)  index of the first channel that expired.
- level_o  out  2  status: INFO=0, ERROR=1, FATAL=2, SUCCESS=3.

Behaviour:
- Reset (async assert, sync release):
  - All channels IDLE; counts 0; limits = DEFAULT_LIMIT.
  - expired_o=0, any_expired_o=0, first_valid_o=0, first_ch_o=0, level_o=INFO.
- Per-channel FSM, all registered on posedge clk:
  - IDLE: arm_i=1 -> COUNTING with count<=0.
  - COUNTING, priority order:
    - arm_i=0 -> IDLE, count<=0.
    - else kick_i=1 -> count<=0.
    - else limit!=0 and count+1>=limit -> EXPIRED.
    - else count<=count+1.
  - EXPIRED: expired_o[ch]=1. Kicks and arm are ignored. Left only by clear_i, to IDLE; the channel re-arms on the following edge if arm_i is still 1.
- Latency: with no kicks, expired_o[ch] rises on the edge exactly `limit` edges after the edge that sampled arm or the last kick.
- Simultaneous events:
  - Kick and expiry on the same edge: kick wins.
  - Disarm and expiry on the same edge: disarm wins.
- Limit writes:
  - cfg_we_i takes effect on the next edge, in any state.
  - The comparison uses >=, so a limit written below the current count expires on the next COUNTING edge unless kicked.
  - limit=0 holds the count at its value; the channel never expires.
  - cfg_ch_i >= NUM_CH: write ignored.
- Counter saturates at all-ones; it never wraps.
- First-expired capture:
  - On the first edge where any channel enters EXPIRED while first_valid_o=0: first_valid_o<=1 and first_ch_o<=lowest-index newly expired channel.
  - Held until clear_i.
- Status level_o (sticky, evaluated on the registered next-state):
  - popcount(expired) >= FATAL_THRESH -> FATAL.
  - else any expired -> ERROR.
  - done_i with no expiry and level INFO -> SUCCESS.
  - Never downgrades; FATAL is terminal until clear_i.
  - done_i is ignored once level is not INFO.
  - Expiry after SUCCESS moves level to ERROR or FATAL.
- clear_i:
  - Synchronous; highest priority over all other events on that edge.
  - Does not alter limits.
- Reset mid-count aborts immediately; outputs go to reset values asynchronously.

Optional Feature:
- Macro: TB_WATCHDOG_LOG_EN.
- Defined:
  - On each edge where a channel enters EXPIRED, print "[<time>] [WATCHDOG] ERROR : channel <n> expired (<limit> cycles)".
  - On entry to FATAL, print "[<time>] [WATCHDOG] FATAL : <k> channels expired" and call $finish.
  - On entry to SUCCESS, print "[<time>] [WATCHDOG] SUCCESS : test done".
- Undefined: no system tasks are compiled; the block is fully synthesizable and all register behaviour is identical.

Test Plan:
- Limit=5 on ch0, arm ch0 at edge 0, no kicks -> expired_o=4'b0001 at edge 5; first_ch_o=0, first_valid_o=1, level_o=ERROR.
- Limit=5 on ch1, arm, kick at edges 3 and 7 -> no expiry through edge 11; expired_o[1] rises at edge 12.
- Ch2 and ch3 limit=4, armed on the same edge (FATAL_THRESH=2) -> both expire on the same edge; first_ch_o=2, level_o=FATAL; kick on the expiry edge prevents expiry on that channel.
- Ch0 counting at count=8 with limit=20, write limit=3 -> expired on the next edge; write limit=0 instead -> never expires over 2000 cycles.
- No expiry, done_i pulse -> level_o=SUCCESS; then ch0 expires -> ERROR; clear_i -> INFO, expired_o=0, first_valid_o=0, limits retained.
- Assert rst_n low mid-count, asynchronously between edges -> all outputs reset immediately; limits return to 1000.
